output_ddr_serializer: RTL and testbench
========================================

// Module: output_ddr_serializer
// PURPOSE
//  Transmit-side counterpart of the input DDR capture path. Accepts WIDTH-bit parallel words
//  over a valid/ready handshake, buffers them 2 deep, and drives 2 bits per CLK into an O_DDR
//  primitive, then an O_BUF, onto pad Q. Provides gapless streaming, idle fill and underrun
//  detection. Sits between fabric logic and the output pad; CLK comes from the CLK_BUF tree.
// PARAMETERS
//  WIDTH     8      word width in bits; even, >=2; beats per word = WIDTH/2
//  IDLE_VAL  2'b00  DDR pair {fall,rise} driven when no word is being sent
// PORTS
//  CLK        in   1      clock, post CLK_BUF
//  RST        in   1      reset, asynchronous, active-high
//  DIN        in   WIDTH  parallel word, bit 0 transmitted first
//  DIN_LAST   in   1      marks the last word of a frame
//  DIN_VALID  in   1      DIN/DIN_LAST valid
//  DIN_READY  out  1      block can accept a word this cycle
//  BUSY       out  1      frame in progress (word shifting or buffered)
//  UNDERRUN   out  1      1-cycle pulse: mid-frame word ended with no successor buffered
//  Q          out  1      pad output (O_DDR -> O_BUF)
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, state IDLE, ddr_d=IDLE_VAL, DIN_READY=0 while
//   RST high and 1 from the first edge after release, BUSY=0, UNDERRUN=0. Reset mid-word abandons
//   the word; ddr_d returns to IDLE_VAL immediately, without waiting for a clock.
//  Handshake: transfer when DIN_VALID&DIN_READY on a rising CLK. DIN_READY = FIFO not full (2 entries).
//   DIN is held stable by the source only while VALID is high and READY is low.
//  ddr_d[1:0] is a register feeding O_DDR.D. ddr_d[0] goes out in the high phase, ddr_d[1] in the low phase.
//  FSM states:
//   IDLE: ddr_d=IDLE_VAL. If FIFO is non-empty, load the head into the shift register, pop, and go to SHIFT.
//   SHIFT: each cycle ddr_d<=sr[1:0], sr>>=2, beat++.
//   On the last beat (beat==WIDTH/2-1):
//    - FIFO non-empty: load next word, pop, stay in SHIFT with no gap cycle.
//    - else if current word's LAST=1: go to IDLE.
//    - else: go to IDLE and pulse UNDERRUN on the following cycle.
//  Latency: a word accepted at edge n into an empty IDLE block has bits[1:0] on ddr_d after edge
//   n+2 and on the pad one O_DDR register stage later.
//  Simultaneous push and pop with the FIFO full is allowed: ready was 0, so no push can occur.
//   Push and pop in the same cycle keeps the count unchanged.
//  BUSY = (state==SHIFT) | FIFO non-empty.
//  Beat counter width = clog2(WIDTH/2), minimum 1. It wraps to 0 on every load.
//  WIDTH==2: every word is a single beat, and back-to-back words stream continuously.
// STRUCTURE
//  Package output_ddr_pkg: state enum (IDLE, SHIFT); localparam BEATS=WIDTH/2; IDLE_VAL default.
//  Sub-module ddr_tx_fifo2: 2-entry {LAST,DIN} FIFO with push, pop, full, empty and head outputs.
//  Top level: FSM, shift register and beat counter, ddr_d register, then primitives
//   O_DDR (D=ddr_d, R=RST, E=1'b1, C=CLK) and O_BUF WEAK_KEEPER="NONE" driving Q.
// TESTING
//  Reset: RST=1 mid-word -> ddr_d==IDLE_VAL with no clock edge, BUSY=0, READY=0; after release READY=1.
//  Single word 8'hA5, LAST=1 -> ddr_d pairs 01,01,10,10 over 4 cycles, then IDLE_VAL; no UNDERRUN.
//  Three words 8'h0F,8'hF0,8'h3C, VALID held high, last has LAST=1 -> 12 consecutive beats with no
//   idle gap; READY drops to 0 while the FIFO is full.
//  Word 8'hFF with LAST=0 and no successor -> 4 beats of 11, then IDLE_VAL; UNDERRUN=1 for exactly
//   one cycle.
//  WIDTH=2, stream 2'b10,2'b01,2'b11 -> ddr_d 10,01,11 on consecutive cycles.
//  Random VALID gaps vs. a golden model of the pad bit stream, checked on both CLK edges at Q.

Source files
------------

// File: rtl/output_ddr_pkg.sv
// Shared types and defaults for the DDR output serializer: FSM state encoding,
// default word geometry and the beat counter sizing helper.
package output_ddr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int         WIDTH_DEFAULT    = 8;
    localparam int         BEATS            = WIDTH_DEFAULT / 2;
    localparam logic [1:0] IDLE_VAL_DEFAULT = 2'b00;

    // Beat counter needs to hold 0..beats-1, but never narrower than one bit.
    function automatic int beat_cnt_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ddr_tx_fifo2.sv
// Two-entry FIFO holding {LAST, DIN} words ahead of the serializer shift register.
module ddr_tx_fifo2 #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage carries no reset; only the pointers and count define validity.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (int'(wr_ptr_reg) == gi)) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/output_ddr_prims.sv
// Behavioural models of the O_DDR output register and O_BUF pad driver; the
// device library provides the real cells at implementation time.
module O_DDR (
    input  logic [1:0] D,
    input  logic       R,
    input  logic       E,
    input  logic       C,
    output logic       Q
);
    logic [1:0] d_q;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            d_q <= 2'b00;
        end else if (E) begin
            d_q <= D;
        end
    end

    // D[0] drives the high phase of C, D[1] the low phase.
    assign Q = C ? d_q[0] : d_q[1];
endmodule

module O_BUF #(
    parameter WEAK_KEEPER = "NONE"
) (
    input  logic I,
    output logic O
);
    // A two-state model cannot show keeper behaviour, so both variants pass I straight through.
    if (WEAK_KEEPER == "NONE") begin : g_no_keeper
        assign O = I;
    end else begin : g_keeper
        assign O = I;
    end
endmodule

// File: rtl/output_ddr_serializer.sv
// Parallel-to-DDR transmit path: 2-deep word buffer, 2-bit-per-clock shifter and
// ddr_d register feeding the O_DDR / O_BUF pad pair.
module output_ddr_serializer
    import output_ddr_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEFAULT,
    parameter logic [1:0] IDLE_VAL = IDLE_VAL_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_LAST,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             BUSY,
    output logic             UNDERRUN,
    output logic             Q
);
    localparam int NUM_BEATS = WIDTH / 2;
    localparam int BW        = beat_cnt_bits(NUM_BEATS);

    tx_state_e        state_reg;
    tx_state_e        state_next;
    logic             ready_en_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH:0]   fifo_head;
    logic             push;
    logic             load;
    logic             underrun_set;
    logic             last_beat;
    logic [WIDTH-1:0] sr_reg;
    logic             last_reg;
    logic [BW-1:0]    beat_reg;
    logic [1:0]       ddr_d;
    logic             underrun_reg;
    logic             ddr_q;

    assign push      = DIN_VALID & DIN_READY;
    assign DIN_READY = ready_en_reg & ~fifo_full;
    assign BUSY      = (state_reg == SHIFT) | ~fifo_empty;
    assign UNDERRUN  = underrun_reg;
    assign last_beat = (beat_reg == BW'(NUM_BEATS - 1));

    ddr_tx_fifo2 #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data ({DIN_LAST, DIN}),
        .pop       (load),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = SHIFT;
            SHIFT:   if (last_beat && fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A successor already buffered at the last beat is loaded in the same edge: no gap cycle.
    always_comb begin
        load         = 1'b0;
        underrun_set = 1'b0;
        case (state_reg)
            IDLE: load = ~fifo_empty;
            SHIFT: begin
                if (last_beat) begin
                    load         = ~fifo_empty;
                    underrun_set = fifo_empty & ~last_reg;
                end
            end
            default: begin
                load         = 1'b0;
                underrun_set = 1'b0;
            end
        endcase
    end

    // ready_en_reg keeps READY low through reset and raises it on the first edge after release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_reg       <= '0;
            last_reg     <= 1'b0;
            beat_reg     <= '0;
            ddr_d        <= IDLE_VAL;
            underrun_reg <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            underrun_reg <= underrun_set;
            if (state_reg == SHIFT) begin
                ddr_d    <= sr_reg[1:0];
                sr_reg   <= sr_reg >> 2;
                beat_reg <= beat_reg + BW'(1);
            end else begin
                ddr_d <= IDLE_VAL;
            end
            if (load) begin
                sr_reg   <= fifo_head[WIDTH-1:0];
                last_reg <= fifo_head[WIDTH];
                beat_reg <= '0;
            end
        end
    end

    O_DDR u_oddr (
        .D (ddr_d),
        .R (RST),
        .E (1'b1),
        .C (CLK),
        .Q (ddr_q)
    );

    O_BUF #(
        .WEAK_KEEPER ("NONE")
    ) u_obuf (
        .I (ddr_q),
        .O (Q)
    );
endmodule

// File: tb/tb_output_ddr_serializer.sv
// Directed and randomized checks of output_ddr_serializer at WIDTH=8 and WIDTH=2.
module tb_output_ddr_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] d8;
    logic       l8, v8, r8, b8, u8, q8;
    logic [1:0] d2;
    logic       l2, v2, r2, b2, u2, q2;

    int vectors;
    int miscompares;
    int und_cnt8;
    int und_cnt2;

    output_ddr_serializer #(.WIDTH(8), .IDLE_VAL(2'b00)) dut8 (
        .CLK(clk), .RST(rst), .DIN(d8), .DIN_LAST(l8), .DIN_VALID(v8),
        .DIN_READY(r8), .BUSY(b8), .UNDERRUN(u8), .Q(q8)
    );

    output_ddr_serializer #(.WIDTH(2), .IDLE_VAL(2'b00)) dut2 (
        .CLK(clk), .RST(rst), .DIN(d2), .DIN_LAST(l2), .DIN_VALID(v2),
        .DIN_READY(r2), .BUSY(b2), .UNDERRUN(u2), .Q(q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u8 === 1'b1) und_cnt8 <= und_cnt8 + 1;
        if (u2 === 1'b1) und_cnt2 <= und_cnt2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the pad stream for the randomized section
    logic [8:0] mq[$];
    logic       m_shift;
    logic [7:0] m_sr;
    logic       m_last;
    int         m_left;
    logic [1:0] m_ddr;
    logic [1:0] m_pad;
    logic [1:0] m_nd;
    logic       m_und;
    logic       m_ready;
    logic [8:0] m_word;

    logic [7:0] words [3];
    logic [1:0] stream_exp [12];
    logic [1:0] w2_words [3];
    logic       rdy_pre;
    int         widx;
    int         acc0;
    int         rdy_low;
    int         und_base;

    initial begin
        vectors = 0; miscompares = 0; und_cnt8 = 0; und_cnt2 = 0;
        rst = 1'b1;
        d8 = '0; l8 = 1'b0; v8 = 1'b0;
        d2 = '0; l2 = 1'b0; v2 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready8", 32'(r8), 32'(1'b0));
        chk("rst_ready2", 32'(r2), 32'(1'b0));
        chk("rst_busy8", 32'(b8), 32'(1'b0));
        chk("rst_ddr_d8", 32'(dut8.ddr_d), 32'(2'b00));
        chk("rst_underrun8", 32'(u8), 32'(1'b0));
        @(negedge clk); rst = 1'b0; #1;
        chk("rel_ready_before_edge", 32'(r8), 32'(1'b0));
        tick();
        chk("rel_ready8", 32'(r8), 32'(1'b1));
        chk("rel_ready2", 32'(r2), 32'(1'b1));

        // Single word A5 with LAST: 01,01,10,10 then idle
        und_base = und_cnt8;
        d8 = 8'hA5; l8 = 1'b1; v8 = 1'b1;
        tick(); v8 = 1'b0;
        chk("a5_busy_buffered", 32'(b8), 32'(1'b1));
        tick(); chk("a5_latency_idle", 32'(dut8.ddr_d), 32'(2'b00));
        tick(); chk("a5_beat0", 32'(dut8.ddr_d), 32'(2'b01));
        tick(); chk("a5_beat1", 32'(dut8.ddr_d), 32'(2'b01));
        tick(); chk("a5_beat2", 32'(dut8.ddr_d), 32'(2'b10));
        tick(); chk("a5_beat3", 32'(dut8.ddr_d), 32'(2'b10));
        tick(); chk("a5_idle_after", 32'(dut8.ddr_d), 32'(2'b00));
        chk("a5_busy_done", 32'(b8), 32'(1'b0));
        tick();
        chk("a5_no_underrun", 32'(und_cnt8 - und_base), 32'(0));

        // Three words back-to-back: 12 beats without a gap, READY low while full
        words = '{8'h0F, 8'hF0, 8'h3C};
        stream_exp = '{2'b11, 2'b11, 2'b00, 2'b00,
                       2'b00, 2'b00, 2'b11, 2'b11,
                       2'b00, 2'b11, 2'b11, 2'b00};
        und_base = und_cnt8;
        widx = 0; acc0 = -1; rdy_low = 0;
        d8 = words[0]; l8 = 1'b0; v8 = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            rdy_pre = r8;
            if (!rdy_pre) rdy_low++;
            tick();
            if (v8 && rdy_pre) begin
                if (widx == 0) acc0 = cyc;
                widx++;
                if (widx == 3) v8 = 1'b0;
                else begin
                    d8 = words[widx];
                    l8 = (widx == 2);
                end
            end
            if (acc0 >= 0 && cyc >= acc0 + 2 && cyc < acc0 + 14)
                chk($sformatf("stream_beat%0d", cyc - acc0 - 2), 32'(dut8.ddr_d), 32'(stream_exp[cyc - acc0 - 2]));
            else if (acc0 >= 0 && cyc == acc0 + 14)
                chk("stream_idle_after", 32'(dut8.ddr_d), 32'(2'b00));
        end
        chk("stream_words_sent", 32'(widx), 32'(3));
        chk("stream_ready_low_cycles", 32'(rdy_low), 32'(3));
        chk("stream_no_underrun", 32'(und_cnt8 - und_base), 32'(0));

        // FF without LAST and no successor: 4 beats of 11, then one-cycle UNDERRUN
        und_base = und_cnt8;
        d8 = 8'hFF; l8 = 1'b0; v8 = 1'b1;
        tick(); v8 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("ff_ddr_d_k%0d", k), 32'(dut8.ddr_d), 32'((k >= 2 && k <= 5) ? 2'b11 : 2'b00));
            chk($sformatf("ff_underrun_k%0d", k), 32'(u8), 32'(k == 5));
        end
        chk("ff_underrun_pulses", 32'(und_cnt8 - und_base), 32'(1));

        // Reset mid-word: ddr_d back to idle with no clock edge
        d8 = 8'h5A; l8 = 1'b1; v8 = 1'b1;
        tick(); v8 = 1'b0;
        tick(); tick(); tick();
        chk("mid_word_beat1", 32'(dut8.ddr_d), 32'(2'b10));
        rst = 1'b1;
        #1;
        chk("arst_ddr_d", 32'(dut8.ddr_d), 32'(2'b00));
        chk("arst_busy", 32'(b8), 32'(1'b0));
        chk("arst_ready", 32'(r8), 32'(1'b0));
        chk("arst_q", 32'(q8), 32'(1'b0));
        tick(); tick();
        @(negedge clk); rst = 1'b0; #1;
        chk("arst_ready_held", 32'(r8), 32'(1'b0));
        tick();
        chk("arst_ready_release", 32'(r8), 32'(1'b1));
        chk("arst_idle_after", 32'(dut8.ddr_d), 32'(2'b00));

        // WIDTH=2: single-beat words stream on consecutive cycles
        w2_words = '{2'b10, 2'b01, 2'b11};
        und_base = und_cnt2;
        v2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d2 = w2_words[k];
            l2 = (k == 2);
            chk($sformatf("w2_ready%0d", k), 32'(r2), 32'(1'b1));
            tick();
        end
        v2 = 1'b0;
        chk("w2_beat0", 32'(dut2.ddr_d), 32'(2'b10));
        tick(); chk("w2_beat1", 32'(dut2.ddr_d), 32'(2'b01));
        tick(); chk("w2_beat2", 32'(dut2.ddr_d), 32'(2'b11));
        tick(); chk("w2_idle_after", 32'(dut2.ddr_d), 32'(2'b00));
        tick(); chk("w2_no_underrun", 32'(und_cnt2 - und_base), 32'(0));

        // Random VALID gaps, pad bit checked on both clock phases against the model
        rst = 1'b1;
        tick(); tick();
        @(negedge clk); rst = 1'b0;
        tick();
        mq.delete();
        m_shift = 1'b0; m_sr = '0; m_last = 1'b0; m_left = 0;
        m_ddr = 2'b00; m_pad = 2'b00; m_und = 1'b0;
        v8 = 1'b0; d8 = '0; l8 = 1'b0;
        for (int i = 0; i < 90; i++) begin
            m_ready = (mq.size() < 2);
            chk("rnd_ready", 32'(r8), 32'(m_ready));
            rdy_pre = m_ready;
            @(posedge clk);
            m_nd = 2'b00;
            m_und = 1'b0;
            if (m_shift) begin
                m_nd = m_sr[1:0];
                m_sr = m_sr >> 2;
                m_left--;
                if (m_left == 0) begin
                    if (mq.size() > 0) begin
                        m_word = mq.pop_front();
                        {m_last, m_sr} = m_word;
                        m_left = 4;
                    end else begin
                        m_shift = 1'b0;
                        m_und = ~m_last;
                    end
                end
            end else if (mq.size() > 0) begin
                m_word = mq.pop_front();
                {m_last, m_sr} = m_word;
                m_left = 4;
                m_shift = 1'b1;
            end
            if (v8 && rdy_pre) mq.push_back({l8, d8});
            m_pad = m_ddr;
            m_ddr = m_nd;
            #1;
            chk($sformatf("rnd_q_high_%0d", i), 32'(q8), 32'(m_pad[0]));
            chk($sformatf("rnd_underrun_%0d", i), 32'(u8), 32'(m_und));
            @(negedge clk); #1;
            chk($sformatf("rnd_q_low_%0d", i), 32'(q8), 32'(m_pad[1]));
            if (!(v8 && !rdy_pre)) begin
                v8 = (i < 60) && ($urandom_range(0, 9) < 6);
                d8 = 8'($urandom);
                l8 = ($urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
